// File: rtl/frame_streamer_pkg.sv
// Shared types and helpers for the frame_streamer sequencer.
package frame_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_RDY = 2'd2
    } state_e;

    // $clog2 that never yields a zero-width field (1 pixel / 1 frame geometries)
    function automatic int clog2_min1(input int value);
        return ($clog2(value) < 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/frame_streamer_addr_gen.sv
// Pixel address and frame index counters for frame_streamer, with end-of-frame
// and end-of-sequence flags. Both counters wrap to 0 on their last value.
module frame_streamer_addr_gen
    import frame_streamer_pkg::*;
#(
    parameter int NUM_PIX    = 307200,
    parameter int NUM_FRAMES = 3,
    parameter int ADDR_W     = clog2_min1(NUM_PIX),
    parameter int FIDX_W     = clog2_min1(NUM_FRAMES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              adv_addr,
    input  logic              adv_frame,
    output logic [ADDR_W-1:0] addr_r,
    output logic [FIDX_W-1:0] frame_r,
    output logic              last_addr_s,
    output logic              last_frame_s
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_PIX - 1);
    localparam logic [FIDX_W-1:0] LAST_FRAME = FIDX_W'(NUM_FRAMES - 1);

    assign last_addr_s  = (addr_r == LAST_ADDR);
    assign last_frame_s = (frame_r == LAST_FRAME);

    // Linear pixel address, advanced once per issued read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r <= {ADDR_W{1'b0}};
        end else if (clear) begin
            addr_r <= {ADDR_W{1'b0}};
        end else if (adv_addr) begin
            addr_r <= last_addr_s ? {ADDR_W{1'b0}} : addr_r + ADDR_W'(1);
        end else begin
            addr_r <= addr_r;
        end
    end

    // Frame index, advanced when the next frame is launched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_r <= {FIDX_W{1'b0}};
        end else if (clear) begin
            frame_r <= {FIDX_W{1'b0}};
        end else if (adv_frame) begin
            frame_r <= last_frame_s ? {FIDX_W{1'b0}} : frame_r + FIDX_W'(1);
        end else begin
            frame_r <= frame_r;
        end
    end

endmodule

// File: rtl/frame_streamer.sv
// Multi-frame raster pixel source reading from a 1-cycle-latency frame memory.
// Define FRAME_STREAMER_LOOP_EN to restart at frame 0 while i_go is held.
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int NUM_FRAMES = 3,
    parameter int PIX_W      = 8,
    parameter int ADDR_W     = clog2_min1(WIDTH * HEIGHT),
    parameter int FIDX_W     = clog2_min1(NUM_FRAMES)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_go,
    input  logic              i_pause,
    input  logic              i_ready,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [FIDX_W-1:0] o_mem_frame,
    input  logic [PIX_W-1:0]  i_mem_data,
    output logic [PIX_W-1:0]  o_pixel,
    output logic              o_valid,
    output logic              o_start,
    output logic              o_frame_end,
    output logic [FIDX_W-1:0] o_frame_idx,
    output logic              o_busy,
    output logic              o_done
);

    state_e              state_r;
    state_e              state_next_s;
    logic                wait_first_r;
    logic                rd_s;
    logic                clear_s;
    logic                adv_frame_s;
    logic                done_s;
    logic                loop_s;
    logic                accept_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [FIDX_W-1:0]   frame_s;
    logic                last_addr_s;
    logic                last_frame_s;
    logic                valid_r;
    logic                start_r;
    logic                end_r;
    logic [FIDX_W-1:0]   fidx_r;
    logic                done_r;

`ifdef FRAME_STREAMER_LOOP_EN
    assign loop_s = i_go;
`else
    assign loop_s = 1'b0;
`endif

    // The first WAIT_RDY cycle has the last pixel still in flight, so i_ready waits
    assign accept_s = (state_r == ST_WAIT_RDY) && !wait_first_r && i_ready;

    frame_streamer_addr_gen #(
        .NUM_PIX    (WIDTH * HEIGHT),
        .NUM_FRAMES (NUM_FRAMES),
        .ADDR_W     (ADDR_W),
        .FIDX_W     (FIDX_W)
    ) u_addr_gen (
        .clk          (i_clk),
        .rst          (i_rst),
        .clear        (clear_s),
        .adv_addr     (rd_s),
        .adv_frame    (adv_frame_s),
        .addr_r       (addr_s),
        .frame_r      (frame_s),
        .last_addr_s  (last_addr_s),
        .last_frame_s (last_frame_s)
    );

    // FSM state register and first-wait-cycle marker
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            wait_first_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            wait_first_r <= (state_r == ST_STREAM) && (state_next_s == ST_WAIT_RDY);
        end
    end

    // FSM next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_go) state_next_s = ST_STREAM;
                else      state_next_s = ST_IDLE;
            end
            ST_STREAM: begin
                if (rd_s && last_addr_s) state_next_s = ST_WAIT_RDY;
                else                     state_next_s = ST_STREAM;
            end
            ST_WAIT_RDY: begin
                if (accept_s) state_next_s = (!last_frame_s || loop_s) ? ST_STREAM : ST_IDLE;
                else          state_next_s = ST_WAIT_RDY;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode: read strobe and counter controls
    always_comb begin
        rd_s        = 1'b0;
        clear_s     = 1'b0;
        adv_frame_s = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE:   clear_s = i_go;
            ST_STREAM: rd_s    = !i_pause;
            ST_WAIT_RDY: begin
                if (accept_s) begin
                    adv_frame_s = !last_frame_s || loop_s;
                    done_s      = last_frame_s && !loop_s;
                end else begin
                    adv_frame_s = 1'b0;
                    done_s      = 1'b0;
                end
            end
            default: rd_s = 1'b0;
        endcase
    end

    // Output stage aligned with the memory's one-cycle read latency
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_r <= 1'b0;
            start_r <= 1'b0;
            end_r   <= 1'b0;
            fidx_r  <= {FIDX_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            valid_r <= rd_s;
            start_r <= rd_s && (addr_s == {ADDR_W{1'b0}});
            end_r   <= rd_s && last_addr_s;
            fidx_r  <= frame_s;
            done_r  <= done_s;
        end
    end

    assign o_mem_rd    = rd_s;
    assign o_mem_addr  = addr_s;
    assign o_mem_frame = frame_s;
    assign o_pixel     = valid_r ? i_mem_data : {PIX_W{1'b0}};
    assign o_valid     = valid_r;
    assign o_start     = start_r;
    assign o_frame_end = end_r;
    assign o_frame_idx = fidx_r;
    assign o_busy      = (state_r != ST_IDLE);
    assign o_done      = done_r;

endmodule

// File: tb/tb_frame_streamer.sv
// Scenario-table bench for frame_streamer (4x2, 2 frames) plus a 1x1 single-frame instance.
`timescale 1ns/1ps
module tb_frame_streamer;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NF   = 2;
    localparam int PW   = 8;
    localparam int NPIX = W * H;
    localparam int AW   = 3;
    localparam int FW   = 1;

    typedef struct {
        string       name;
        logic [31:0] pause_mask;
        int          ready_at;
        int          go_until;
        int          nframes;
        int          exp_start2;
        int          exp_done;
    } scen_t;

    typedef struct {
        int frame;
        int addr;
    } rd_t;

    typedef struct packed {
        logic [PW-1:0] pix;
        logic          st;
        logic          en;
        logic [FW-1:0] idx;
    } out_t;

    logic          clk = 1'b0;
    logic          rst, go, pause, ready, go1;
    logic          mem_rd, valid, start, fend, busy, done;
    logic [AW-1:0] mem_addr;
    logic [FW-1:0] mem_frame, fidx;
    logic [PW-1:0] mem_data = 8'hEE;
    logic [PW-1:0] pixel;
    logic          mem_rd1, valid1, start1, fend1, busy1, done1;
    logic [0:0]    mem_addr1, mem_frame1, fidx1;
    logic [PW-1:0] mem_data1 = 8'hEE;
    logic [PW-1:0] pixel1;

    int checks = 0;
    int errors = 0;
    rd_t  rd_q[$];
    out_t out_q[$];
    scen_t tbl[4];

    always #5 clk = ~clk;

    frame_streamer #(.WIDTH(W), .HEIGHT(H), .NUM_FRAMES(NF), .PIX_W(PW)) dut (
        .i_clk(clk), .i_rst(rst), .i_go(go), .i_pause(pause), .i_ready(ready),
        .o_mem_rd(mem_rd), .o_mem_addr(mem_addr), .o_mem_frame(mem_frame),
        .i_mem_data(mem_data), .o_pixel(pixel), .o_valid(valid), .o_start(start),
        .o_frame_end(fend), .o_frame_idx(fidx), .o_busy(busy), .o_done(done)
    );

    frame_streamer #(.WIDTH(1), .HEIGHT(1), .NUM_FRAMES(1), .PIX_W(PW)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_go(go1), .i_pause(1'b0), .i_ready(ready),
        .o_mem_rd(mem_rd1), .o_mem_addr(mem_addr1), .o_mem_frame(mem_frame1),
        .i_mem_data(mem_data1), .o_pixel(pixel1), .o_valid(valid1), .o_start(start1),
        .o_frame_end(fend1), .o_frame_idx(fidx1), .o_busy(busy1), .o_done(done1)
    );

    function automatic logic [PW-1:0] pix_fn(input int f, input int a);
        return PW'((f * 64 + a * 17 + 5) & 255);
    endfunction

    // Frame memory models: data valid one cycle after the read strobe
    always @(posedge clk) begin
        mem_data  <= mem_rd  ? pix_fn(int'(mem_frame), int'(mem_addr)) : 8'hEE;
        mem_data1 <= mem_rd1 ? 8'h3C : 8'hEE;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic run_scen(input scen_t s);
        rd_t  e;
        out_t eo;
        int   n_start = 0;
        int   start2  = -1;
        int   donec   = -1;
        rd_q.delete();
        out_q.delete();
        for (int k = 0; k < s.nframes; k++)
            for (int a = 0; a < NPIX; a++) rd_q.push_back('{k % NF, a});
        @(negedge clk);
        go = 1'b1; pause = 1'b0; ready = (s.ready_at <= 0);
        for (int c = 0; c < 80 && donec < 0; c++) begin
            @(negedge clk);
            go    = (c < s.go_until);
            pause = (c < 32) ? s.pause_mask[c] : 1'b0;
            ready = (c >= s.ready_at);
            #1;
            if (c == 0) chk({s.name, "_busy_start"}, 64'(busy), 64'd1);
            if (mem_rd) begin
                if (rd_q.size() == 0) chk({s.name, "_rd_extra"}, 64'(mem_addr), 64'hFFFF);
                else begin
                    e = rd_q.pop_front();
                    chk({s.name, "_rd_addr"}, 64'({mem_frame, mem_addr}), 64'({FW'(e.frame), AW'(e.addr)}));
                    eo.pix = pix_fn(e.frame, e.addr);
                    eo.st  = (e.addr == 0);
                    eo.en  = (e.addr == NPIX - 1);
                    eo.idx = FW'(e.frame);
                    out_q.push_back(eo);
                end
            end
            if (valid) begin
                if (out_q.size() == 0) chk({s.name, "_out_extra"}, 64'(pixel), 64'hFFFF);
                else begin
                    eo = out_q.pop_front();
                    chk({s.name, "_out"}, 64'({pixel, start, fend, fidx}), 64'(eo));
                end
                if (start) begin
                    n_start++;
                    if (n_start == 1) chk({s.name, "_start1_cyc"}, 64'(c), 64'd1);
                    if (n_start == 2) start2 = c;
                end
            end else begin
                chk({s.name, "_pix_idle"}, 64'(pixel), 64'd0);
            end
            if (done) begin
                donec = c;
                chk({s.name, "_busy_at_done"}, 64'(busy), 64'd0);
            end
        end
        go = 1'b0; pause = 1'b0; ready = 1'b1;
        chk({s.name, "_done_cyc"}, 64'(donec), 64'(s.exp_done));
        chk({s.name, "_start2_cyc"}, 64'(start2), 64'(s.exp_start2));
        chk({s.name, "_q_empty"}, 64'(rd_q.size() + out_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int found;
        int ndone;
        int nvalid;
        int donec1;
        tbl[0] = '{"basic",   32'h0000_0000,  0, 0, 2, 11, 20};
        tbl[1] = '{"pause",   32'h0000_000C,  0, 0, 2, 13, 22};
        tbl[2] = '{"rdyhold", 32'h0000_0000, 28, 0, 2, 30, 39};
`ifdef FRAME_STREAMER_LOOP_EN
        tbl[3] = '{"loop",    32'h0000_0000,  0, 32, 4, 11, 40};
`else
        tbl[3] = '{"goheld",  32'h0000_0000,  0, 15, 2, 11, 20};
`endif
        rst = 1'b1; go = 1'b0; go1 = 1'b0; pause = 1'b0; ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outs", 64'({mem_rd, mem_addr, mem_frame, pixel, valid, start, fend, fidx, busy, done}), 64'd0);
        chk("reset_outs1", 64'({mem_rd1, pixel1, valid1, busy1, done1}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run_scen(tbl[i]);

        // Reset in the middle of frame 1: immediate clear, no completion afterwards
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            #1;
            if (mem_rd && mem_frame == 1'b1 && mem_addr == 3'd5) found = 1;
            else @(negedge clk);
        end
        chk("rst_reach_addr5", 64'(found), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", 64'({mem_rd, mem_addr, mem_frame, pixel, valid, start, fend, fidx, busy, done}), 64'd0);
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(negedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("rst_no_done", 64'(ndone), 64'd0);
        run_scen(tbl[0]);

        // 1x1 single-frame geometry
        @(negedge clk); go1 = 1'b1; ready = 1'b1;
        nvalid = 0; donec1 = -1;
        for (int c = 0; c < 12 && donec1 < 0; c++) begin
            @(negedge clk); go1 = 1'b0; #1;
            if (valid1) begin
                nvalid++;
                chk("one_pix_flags", 64'({pixel1, start1, fend1, fidx1}), 64'({8'h3C, 1'b1, 1'b1, 1'b0}));
            end
            if (done1) donec1 = c;
        end
        chk("one_pix_nvalid", 64'(nvalid), 64'd1);
        chk("one_pix_done_cyc", 64'(donec1), 64'd3);
        chk("one_pix_busy", 64'(busy1), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
